// File: rtl/decode_pkg.sv
// Shared MIPS decode encodings and the decoded-fields struct used by the decoder and datapath.
package decode_pkg;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpSlti  = 6'h0A;
  localparam logic [5:0] OpAndi  = 6'h0C;
  localparam logic [5:0] OpOri   = 6'h0D;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;
  localparam logic [5:0] FnAnd = 6'h24;
  localparam logic [5:0] FnOr  = 6'h25;
  localparam logic [5:0] FnNor = 6'h27;
  localparam logic [5:0] FnSlt = 6'h2A;

  localparam logic [3:0] AluAnd = 4'b0000;
  localparam logic [3:0] AluOr  = 4'b0001;
  localparam logic [3:0] AluAdd = 4'b0010;
  localparam logic [3:0] AluSub = 4'b0110;
  localparam logic [3:0] AluSlt = 4'b0111;
  localparam logic [3:0] AluNor = 4'b1100;

  typedef struct packed {
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic        alu_src;
    logic [3:0]  alu_ctrl;
    logic        reg_write;
    logic        reg_dst;
    logic        illegal;
  } decoded_t;

endpackage

// File: rtl/instr_decode_logic.sv
// Combinational mapping of a MIPS instruction word onto decoded_t.
module instr_decode_logic
  import decode_pkg::*;
(
  input  logic [31:0] instr,
  output decoded_t    dec
);

  always_comb begin
    dec          = '0;
    dec.rs       = instr[25:21];
    dec.rt       = instr[20:16];
    dec.rd       = instr[15:11];
    dec.imm      = instr[15:0];
    dec.alu_ctrl = AluAdd;
    dec.illegal  = 1'b1;
    case (instr[31:26])
      OpRtype: begin
        dec.illegal   = 1'b0;
        dec.reg_dst   = 1'b1;
        dec.reg_write = 1'b1;
        case (instr[5:0])
          FnAdd:   dec.alu_ctrl = AluAdd;
          FnSub:   dec.alu_ctrl = AluSub;
          FnAnd:   dec.alu_ctrl = AluAnd;
          FnOr:    dec.alu_ctrl = AluOr;
          FnNor:   dec.alu_ctrl = AluNor;
          FnSlt:   dec.alu_ctrl = AluSlt;
          default: begin
            // Unknown funct falls back to the same safe controls as an unknown opcode.
            dec.illegal   = 1'b1;
            dec.reg_dst   = 1'b0;
            dec.reg_write = 1'b0;
          end
        endcase
      end
      OpAddi, OpAndi, OpOri, OpSlti, OpLw, OpSw: begin
        dec.illegal   = 1'b0;
        dec.alu_src   = 1'b1;
        dec.reg_write = (instr[31:26] != OpSw);
        case (instr[31:26])
          OpAndi:  dec.alu_ctrl = AluAnd;
          OpOri:   dec.alu_ctrl = AluOr;
          OpSlti:  dec.alu_ctrl = AluSlt;
          default: dec.alu_ctrl = AluAdd;
        endcase
      end
      OpBeq: begin
        dec.illegal  = 1'b0;
        dec.alu_ctrl = AluSub;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/instr_decode.sv
// Decode stage with a two-entry (output + skid) ready/valid buffer.
// Define INSTR_DECODE_ILLEGAL_COUNT_EN to build the saturating illegal_count counter.
module instr_decode
  import decode_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  output logic        dec_valid,
  input  logic        out_ready,
  output logic [4:0]  rs_number,
  output logic [4:0]  rt_number,
  output logic [4:0]  rd_number,
  output logic [15:0] imm_16,
  output logic        ALUSrc,
  output logic [3:0]  ALUControl,
  output logic        RegWrite,
  output logic        RegDst,
  output logic        illegal,
  output logic [15:0] illegal_count
);

  decoded_t dec;
  decoded_t out_q, out_d, skid_q, skid_d;
  logic     out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
  logic     ready_q;
  logic     in_fire, out_fire;

  instr_decode_logic u_logic (
    .instr (instr),
    .dec   (dec)
  );

  assign in_fire  = instr_valid && ready_q;
  assign out_fire = out_valid_q && out_ready;

  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (out_fire || !out_valid_q) begin
      // ready_q is low whenever the skid holds data, so in_fire cannot coincide here.
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = in_fire;
        if (in_fire) out_d = dec;
      end
    end else if (in_fire) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      ready_q      <= !skid_valid_d;
    end
  end

`ifdef INSTR_DECODE_ILLEGAL_COUNT_EN
  logic [15:0] illegal_count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      illegal_count_q <= 16'h0000;
    end else if (in_fire && dec.illegal && (illegal_count_q != 16'hFFFF)) begin
      illegal_count_q <= illegal_count_q + 16'd1;
    end
  end

  assign illegal_count = illegal_count_q;
`else
  assign illegal_count = 16'h0000;
`endif

  assign instr_ready = ready_q;
  assign dec_valid   = out_valid_q;
  assign rs_number   = out_q.rs;
  assign rt_number   = out_q.rt;
  assign rd_number   = out_q.rd;
  assign imm_16      = out_q.imm;
  assign ALUSrc      = out_q.alu_src;
  assign ALUControl  = out_q.alu_ctrl;
  assign RegWrite    = out_q.reg_write;
  assign RegDst      = out_q.reg_dst;
  assign illegal     = out_q.illegal;

endmodule
